// File: rtl/conv_out_packer.sv
// conv_out_packer
//   Collects 3x3 convolution engine results (two signed 16-bit samples per
//   valid flag), optionally clamps negatives to zero, packs two consecutive
//   pairs into one 64-bit word and queues the words in a small FIFO that is
//   drained over a valid/ready handshake. Words are tagged with a frame-last
//   flag, and a sticky overflow flag records any word dropped on a full FIFO.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   en          capture enable; gates v_flag and flush only
//   v_flag      engine result valid, one cycle per pair
//   outa, outb  engine results A/B, signed 16-bit
//   flush       pulse: emit any partial word and close the frame
//   out_data    FIFO head word, 0 when empty
//   out_last    head word is the last word of its frame
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head word
//   fifo_count  FIFO occupancy
//   overflow    sticky, a word was dropped because the FIFO was full
//
// Lane state machine
//   state | meaning
//   LANE0 | no pair held; next capture goes to hold
//   LANE1 | one pair in hold; next capture completes a word

module conv_out_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_WORDS = 8,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          v_flag,
    input  logic [15:0]                   outa,
    input  logic [15:0]                   outb,
    input  logic                          flush,
    output logic [63:0]                   out_data,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [WW-1:0] W_LAST   = WW'(FRAME_WORDS - 1);
    localparam logic [WW-1:0] W_ONE    = WW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_t;

    lane_t          state;
    lane_t          state_nxt;
    logic [31:0]    hold;
    logic [WW-1:0]  word_idx;

    logic           capture;
    logic           flush_acc;
    logic [15:0]    a_s;
    logic [15:0]    b_s;
    logic [31:0]    pair;

    logic           push;
    logic [63:0]    push_data;
    logic           push_last;
    logic           hold_load;

    assign capture   = en & v_flag;
    assign flush_acc = en & flush;
    assign a_s       = (RELU_EN && outa[15]) ? 16'h0000 : outa;
    assign b_s       = (RELU_EN && outb[15]) ? 16'h0000 : outb;
    assign pair      = {b_s, a_s};

    // ------------------------------------------------------------------
    // Lane state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LANE0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // A capture together with a flush emits the half word at once,
            // so the lane stays empty.
            LANE0: if (capture && !flush_acc) state_nxt = LANE1;
            LANE1: if (capture || flush_acc)  state_nxt = LANE0;
            default: state_nxt = LANE0;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        push_last = 1'b0;
        hold_load = 1'b0;
        case (state)
            LANE0: begin
                if (capture) begin
                    hold_load = 1'b1;
                    if (flush_acc) begin
                        push      = 1'b1;
                        push_data = {32'h0000_0000, pair};
                        push_last = 1'b1;
                    end
                end
            end
            LANE1: begin
                if (capture) begin
                    push      = 1'b1;
                    push_data = {pair, hold};
                    push_last = (word_idx == W_LAST) || flush_acc;
                end else if (flush_acc) begin
                    push      = 1'b1;
                    push_data = {32'h0000_0000, hold};
                    push_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Hold register and frame word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold     <= '0;
            word_idx <= '0;
        end else begin
            if (hold_load) begin
                hold <= pair;
            end
            // The counter advances even when the FIFO drops the word.
            if (flush_acc || (push && push_last)) begin
                word_idx <= '0;
            end else if (push) begin
                word_idx <= word_idx + W_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO, entries are {last, data}
    // ------------------------------------------------------------------
    logic [64:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           pop;
    logic           full;
    logic           wr_en;
    logic           drop;
    logic [64:0]    head;

    assign pop   = out_valid & out_ready;
    assign full  = (fifo_count == CNT_FULL);
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stale memory contents are masked so an empty FIFO always shows zero.
    assign head      = mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? head[63:0] : 64'h0;
    assign out_last  = out_valid & head[64];

endmodule

// File: tb/tb_conv_out_packer.sv
// Testbench for conv_out_packer. Two instances share the stimulus:
//   d0: FIFO_DEPTH=4, FRAME_WORDS=8, RELU_EN=1
//   d1: FIFO_DEPTH=4, FRAME_WORDS=2, RELU_EN=0
// A queue-based reference model predicts every output after each clock.

module tb_conv_out_packer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        v_flag;
    logic [15:0] outa;
    logic [15:0] outb;
    logic        flush;
    logic        out_ready;

    logic [63:0] d0_data,  d1_data;
    logic        d0_last,  d1_last;
    logic        d0_valid, d1_valid;
    logic [2:0]  d0_count, d1_count;
    logic        d0_ovf,   d1_ovf;

    int n_cmp;
    int n_err;

    conv_out_packer #(.FIFO_DEPTH(4), .FRAME_WORDS(8), .RELU_EN(1'b1)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .v_flag(v_flag), .outa(outa), .outb(outb),
        .flush(flush), .out_data(d0_data), .out_last(d0_last), .out_valid(d0_valid),
        .out_ready(out_ready), .fifo_count(d0_count), .overflow(d0_ovf)
    );

    conv_out_packer #(.FIFO_DEPTH(4), .FRAME_WORDS(2), .RELU_EN(1'b0)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .v_flag(v_flag), .outa(outa), .outb(outb),
        .flush(flush), .out_data(d1_data), .out_last(d1_last), .out_valid(d1_valid),
        .out_ready(out_ready), .fifo_count(d1_count), .overflow(d1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: pending pair count, held pair, frame word count,
    // overflow flag and a queue of {last, data} words per instance.
    // ------------------------------------------------------------------
    logic [64:0] q0[$];
    logic [64:0] q1[$];
    int          pend [2];
    logic [31:0] held [2];
    int          wcnt [2];
    bit          ovf  [2];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [64:0] qhead(input int k);
        if (qsize(k) == 0) return 65'h0;
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0;
            held[k] = '0;
            wcnt[k] = 0;
            ovf[k]  = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int          fw;
        bit          relu;
        logic [15:0] a;
        logic [15:0] b;
        logic [63:0] w;
        bit          psh;
        bit          lst;
        int          sz;
        fw   = (k == 0) ? 8 : 2;
        relu = (k == 0);
        sz   = qsize(k);
        psh  = 1'b0;
        lst  = 1'b0;
        w    = '0;
        if (en && v_flag) begin
            a = (relu && outa[15]) ? 16'h0 : outa;
            b = (relu && outb[15]) ? 16'h0 : outb;
            if (pend[k] == 0) begin
                held[k] = {b, a};
                pend[k] = 1;
            end else begin
                w       = {b, a, held[k]};
                pend[k] = 0;
                psh     = 1'b1;
                lst     = (wcnt[k] == fw - 1);
            end
        end
        if (en && flush) begin
            if (pend[k] == 1) begin
                w       = {32'h0, held[k]};
                pend[k] = 0;
                psh     = 1'b1;
                lst     = 1'b1;
            end else if (psh) begin
                lst = 1'b1;
            end
        end
        if (psh) wcnt[k] = lst ? 0 : wcnt[k] + 1;
        if (en && flush) wcnt[k] = 0;
        if (sz > 0 && out_ready) begin
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
        if (psh) begin
            if (qsize(k) < 4) begin
                if (k == 0) q0.push_back({lst, w});
                else        q1.push_back({lst, w});
            end else begin
                ovf[k] = 1'b1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_dut(input int k, input logic [63:0] data, input logic last,
                               input logic valid, input logic [2:0] count, input logic ov);
        logic [64:0] h;
        h = qhead(k);
        check_eq($sformatf("d%0d_valid", k), 64'(valid), 64'(qsize(k) > 0));
        check_eq($sformatf("d%0d_data", k),  data,       h[63:0]);
        check_eq($sformatf("d%0d_last", k),  64'(last),  64'(h[64]));
        check_eq($sformatf("d%0d_count", k), 64'(count), 64'(qsize(k)));
        check_eq($sformatf("d%0d_ovf", k),   64'(ov),    64'(ovf[k]));
    endtask

    task automatic compare_all();
        compare_dut(0, d0_data, d0_last, d0_valid, d0_count, d0_ovf);
        compare_dut(1, d1_data, d1_last, d1_valid, d1_count, d1_ovf);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all();
    endtask

    task automatic idle();
        en = 1'b1; v_flag = 1'b0; flush = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        en = 1'b1; v_flag = 1'b1; flush = 1'b0; outa = a; outb = b;
        cyc();
    endtask

    // Asynchronous reset applied and released between clock edges.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        en = 1'b0; v_flag = 1'b0; flush = 1'b0;
        outa = '0; outb = '0; out_ready = 1'b1;
        model_reset();
        #3;
        compare_all();
        #10;
        rst = 1'b1;

        // Basic packing, immediately drained
        out_ready = 1'b1;
        send(16'h0001, 16'h0002);
        send(16'h0003, 16'h0004);
        check_eq("tp1_word", d0_data, 64'h0004_0003_0002_0001);
        check_eq("tp1_last", 64'(d0_last), 64'h0);
        idle(); cyc();
        check_eq("tp1_drained", 64'(d0_count), 64'h0);

        // Clamp versus pass-through
        send(16'hFFFF, 16'h7FFF);
        send(16'h8000, 16'h0010);
        check_eq("relu_on",  d0_data, 64'h0010_0000_7FFF_0000);
        check_eq("relu_off", d1_data, 64'h0010_8000_7FFF_FFFF);
        idle(); cyc();

        // Partial word closed by flush
        send(16'h1234, 16'h5678);
        idle(); flush = 1'b1; cyc();
        check_eq("flush_word", d0_data, 64'h0000_0000_5678_1234);
        check_eq("flush_last", 64'(d0_last), 64'h1);
        idle(); cyc();
        send(16'h0011, 16'h0022);
        send(16'h0033, 16'h0044);
        check_eq("post_flush_last", 64'(d0_last), 64'h0);
        idle(); cyc();

        // Overflow: five words into a four-entry FIFO with no drain
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(16'(i * 2 + 1), 16'(i * 2 + 2));
        idle();
        check_eq("ovf_count", 64'(d0_count), 64'h4);
        check_eq("ovf_flag",  64'(d0_ovf),   64'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();

        // Same traffic, but the consumer takes one word on the fifth push
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            out_ready = (i == 9);
            send(16'(i + 16'h100), 16'(i + 16'h200));
        end
        idle(); out_ready = 1'b0;
        check_eq("no_ovf_flag", 64'(d0_ovf), 64'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();

        // Reset mid-frame with two words queued and one pair held
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(16'hA000 + 16'(i), 16'h0B00 + 16'(i));
        idle();
        check_eq("pre_rst_count", 64'(d0_count), 64'h2);
        do_reset();
        check_eq("rst_valid", 64'(d0_valid), 64'h0);
        out_ready = 1'b1;
        send(16'h1111, 16'h2222);
        send(16'h3333, 16'h4444);
        check_eq("post_rst_word", d0_data, 64'h4444_3333_2222_1111);
        idle(); cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(7) != 0);
            v_flag    = ($urandom_range(3) != 0);
            flush     = ($urandom_range(15) == 0);
            outa      = 16'($urandom);
            outb      = 16'($urandom);
            out_ready = (i % 600 < 300) ? ($urandom_range(2) != 0) : ($urandom_range(3) == 0);
            cyc();
            if (i % 750 == 749) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
